// File: rtl/mem_dump_tx.sv
// mem_dump_tx: reads word_count words from a synchronous data memory starting
// at base_addr (address wraps modulo 2^ADDR_W) and streams them out over a
// valid/ready interface, marking the final word with out_last.
// Optional feature macro: DUMP_CHECKSUM_EN -- appends the XOR of all streamed
// data words as one extra final word.
module mem_dump_tx #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

`ifdef DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {
    IDLE = 3'd0, READ = 3'd1, WAIT = 3'd2, SEND = 3'd3, CSUM = 3'd4, DONE = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE = 3'd0, READ = 3'd1, WAIT = 3'd2, SEND = 3'd3, DONE = 3'd5
  } state_t;
`endif

  localparam logic [ADDR_W:0]   CNT_ZERO  = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

`ifdef DUMP_CHECKSUM_EN
  // Running XOR checksum: fold one more data word into the accumulator.
  function automatic logic [DATA_W-1:0] csum_fold(input logic [DATA_W-1:0] acc,
                                                  input logic [DATA_W-1:0] word);
    csum_fold = acc ^ word;
  endfunction
`endif

  state_t              state_r, state_s;
  logic [ADDR_W-1:0]   base_r, base_s;
  logic [ADDR_W:0]     count_r, count_s;
  logic [ADDR_W:0]     index_r, index_s;
  logic [ADDR_W-1:0]   mem_addr_r, mem_addr_s;
  logic                mem_rd_en_r, mem_rd_en_s;
  logic                out_valid_r, out_valid_s;
  logic [DATA_W-1:0]   out_data_r, out_data_s;
  logic                out_last_r, out_last_s;
  logic                done_r, done_s;
  logic                busy_r, busy_s;
`ifdef DUMP_CHECKSUM_EN
  logic [DATA_W-1:0]   csum_r, csum_s;
`endif

  logic [ADDR_W:0]     idx_inc_s;
  logic                xfer_s;
  logic                more_s;

  assign idx_inc_s = index_r + CNT_ONE;
  assign xfer_s    = out_valid_r & out_ready;
  assign more_s    = (idx_inc_s < count_r);

  // Next-state and next-output decode; every register holds or clears by default.
  always_comb begin
    state_s     = state_r;
    base_s      = base_r;
    count_s     = count_r;
    index_s     = index_r;
    mem_addr_s  = mem_addr_r;
    mem_rd_en_s = 1'b0;
    out_valid_s = 1'b0;
    out_data_s  = out_data_r;
    out_last_s  = 1'b0;
    done_s      = 1'b0;
`ifdef DUMP_CHECKSUM_EN
    csum_s      = csum_r;
`endif
    case (state_r)
      IDLE: begin
        if (start) begin
          if (word_count != CNT_ZERO) begin
            base_s      = base_addr;
            count_s     = word_count;
            index_s     = CNT_ZERO;
            mem_addr_s  = base_addr;
            mem_rd_en_s = 1'b1;
`ifdef DUMP_CHECKSUM_EN
            csum_s      = DATA_ZERO;
`endif
            state_s     = READ;
          end else begin
`ifdef DUMP_CHECKSUM_EN
            // Empty dump still emits the (zero) checksum word.
            csum_s      = DATA_ZERO;
            out_data_s  = DATA_ZERO;
            out_valid_s = 1'b1;
            out_last_s  = 1'b1;
            state_s     = CSUM;
`else
            done_s      = 1'b1;
            state_s     = DONE;
`endif
          end
        end else begin
          state_s = IDLE;
        end
      end
      READ: begin
        // Read strobe was registered on entry; data arrives during WAIT.
        state_s = WAIT;
      end
      WAIT: begin
        out_data_s  = mem_rdata;
        out_valid_s = 1'b1;
`ifdef DUMP_CHECKSUM_EN
        out_last_s  = 1'b0;
`else
        out_last_s  = (idx_inc_s == count_r);
`endif
        state_s     = SEND;
      end
      SEND: begin
        if (xfer_s) begin
          index_s = idx_inc_s;
`ifdef DUMP_CHECKSUM_EN
          csum_s  = csum_fold(csum_r, out_data_r);
`endif
          if (more_s) begin
            mem_addr_s  = base_r + idx_inc_s[ADDR_W-1:0];
            mem_rd_en_s = 1'b1;
            state_s     = READ;
          end else begin
`ifdef DUMP_CHECKSUM_EN
            out_data_s  = csum_fold(csum_r, out_data_r);
            out_valid_s = 1'b1;
            out_last_s  = 1'b1;
            state_s     = CSUM;
`else
            done_s      = 1'b1;
            state_s     = DONE;
`endif
          end
        end else begin
          out_valid_s = 1'b1;
          out_last_s  = out_last_r;
          state_s     = SEND;
        end
      end
`ifdef DUMP_CHECKSUM_EN
      CSUM: begin
        if (xfer_s) begin
          done_s  = 1'b1;
          state_s = DONE;
        end else begin
          out_valid_s = 1'b1;
          out_last_s  = 1'b1;
          state_s     = CSUM;
        end
      end
`endif
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    busy_s = (state_s != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      base_r      <= ADDR_ZERO;
      count_r     <= CNT_ZERO;
      index_r     <= CNT_ZERO;
      mem_addr_r  <= ADDR_ZERO;
      mem_rd_en_r <= 1'b0;
      out_valid_r <= 1'b0;
      out_data_r  <= DATA_ZERO;
      out_last_r  <= 1'b0;
      done_r      <= 1'b0;
      busy_r      <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
      csum_r      <= DATA_ZERO;
`endif
    end else begin
      state_r     <= state_s;
      base_r      <= base_s;
      count_r     <= count_s;
      index_r     <= index_s;
      mem_addr_r  <= mem_addr_s;
      mem_rd_en_r <= mem_rd_en_s;
      out_valid_r <= out_valid_s;
      out_data_r  <= out_data_s;
      out_last_r  <= out_last_s;
      done_r      <= done_s;
      busy_r      <= busy_s;
`ifdef DUMP_CHECKSUM_EN
      csum_r      <= csum_s;
`endif
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign mem_addr  = mem_addr_r;
  assign mem_rd_en = mem_rd_en_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_last  = out_last_r;

endmodule

// File: tb/tb_mem_dump_tx.sv
// Self-checking bench for mem_dump_tx: a transaction-level model predicts the
// read addresses and stream words of each dump; a negedge monitor compares
// every meaningful DUT output cycle against it. Directed tests add literal
// expectations (latency, wrap, stalls, empty dump, mid-dump reset).
module tb_mem_dump_tx;
  localparam int AW = 8;
  localparam int DW = 32;
`ifdef DUMP_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, start, out_ready;
  logic [AW-1:0] base_addr;
  logic [AW:0]   word_count;
  logic          busy, done, mem_rd_en, out_valid, out_last;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata, out_data;

  always #5 clk = ~clk;

  mem_dump_tx #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .word_count(word_count), .busy(busy), .done(done), .mem_addr(mem_addr),
    .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );

  // Synchronous data memory: data valid the cycle after the strobe.
  logic [DW-1:0] mem [0:255];
  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail_now(input string name, input logic [63:0] act);
    n_checks++;
    $display("FAIL %s: got %0h, required nothing (cycle %0d)", name, act, cyc);
  endtask

  // Model state: expected reads and expected stream words {last, data}.
  logic [AW-1:0] exp_addr_q[$];
  logic [DW:0]   exp_word_q[$];
  logic [AW-1:0] seen_addr_q[$];
  logic [DW-1:0] seen_word_q[$];
  bit            expect_done = 1'b0;
  bit            first_seen;
  int            first_valid_cyc, last_xfer_cyc, done_cyc;

  task automatic model_load(input logic [AW-1:0] b, input int n);
    logic [AW-1:0] a;
    logic [DW-1:0] acc;
    acc = '0;
    exp_addr_q.delete(); exp_word_q.delete();
    seen_addr_q.delete(); seen_word_q.delete();
    for (int i = 0; i < n; i++) begin
      a = b + AW'(i);
      exp_addr_q.push_back(a);
      acc = acc ^ mem[a];
      exp_word_q.push_back({(i == n - 1) && !CS, mem[a]});
    end
    if (CS) exp_word_q.push_back({1'b1, acc});
    expect_done     = 1'b1;
    first_seen      = 1'b0;
    first_valid_cyc = -1;
    last_xfer_cyc   = -1;
    done_cyc        = -1;
  endtask

  // Compare process: checks reads, stream words and done against the model.
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_rd_en) begin
        seen_addr_q.push_back(mem_addr);
        if (exp_addr_q.size() == 0) fail_now("unexpected_read", 64'(mem_addr));
        else begin
          check("read_addr", 64'(mem_addr), 64'(exp_addr_q[0]));
          void'(exp_addr_q.pop_front());
        end
      end
      if (out_valid) begin
        if (!first_seen) begin first_seen = 1'b1; first_valid_cyc = cyc; end
        if (exp_word_q.size() == 0) fail_now("unexpected_word", 64'(out_data));
        else begin
          check("out_data", 64'(out_data), 64'(exp_word_q[0][DW-1:0]));
          check("out_last", 64'(out_last), 64'(exp_word_q[0][DW]));
          if (out_ready) begin
            seen_word_q.push_back(out_data);
            last_xfer_cyc = cyc;
            void'(exp_word_q.pop_front());
          end
        end
      end
      if (done) begin
        if (!expect_done) fail_now("unexpected_done", 64'(done));
        else check("drained_at_done", 64'(exp_addr_q.size() + exp_word_q.size()), 64'(0));
        done_cyc    = cyc;
        expect_done = 1'b0;
      end
    end
  end

  task automatic run_dump(input logic [AW-1:0] b, input int n, input int stall,
                          output int start_cyc);
    int k, wait_cnt;
    model_load(b, n);
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; word_count = (AW+1)'(n);
    out_ready = (stall == 0);
    start_cyc = cyc;
    k = 0; wait_cnt = 0;
    while (expect_done && k < 300) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (out_valid) begin
        if (wait_cnt >= stall) begin out_ready = 1'b1; wait_cnt = 0; end
        else begin out_ready = 1'b0; wait_cnt++; end
      end else begin
        out_ready = (stall == 0);
      end
      k++;
    end
    if (expect_done) begin
      fail_now("dump_timeout", 64'(k));
      expect_done = 1'b0;
    end
    @(posedge clk); #1;
    check("busy_after_done", 64'(busy), 64'(0));
  endtask

  int sc, k;

  initial begin
    reset = 1'b1; start = 1'b0; base_addr = '0; word_count = '0; out_ready = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h5A00_0000 + 32'(i);
    mem[0] = 32'd6; mem[1] = 32'd7; mem[2] = 32'd8;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_mem_rd_en", 64'(mem_rd_en), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    reset = 1'b0;

    // Basic dump 6,7,8 with ready always high.
    run_dump(8'h00, 3, 0, sc);
    check("t1_first_valid_latency", 64'(first_valid_cyc - sc), 64'(3));
    check("t1_nwords", 64'(seen_word_q.size()), 64'(CS ? 4 : 3));
    check("t1_w0", 64'(seen_word_q[0]), 64'(6));
    check("t1_w1", 64'(seen_word_q[1]), 64'(7));
    check("t1_w2", 64'(seen_word_q[2]), 64'(8));
    if (CS) check("t1_csum", 64'(seen_word_q[3]), 64'(32'h0000_0009));
    check("t1_done_after_last_xfer", 64'(done_cyc - last_xfer_cyc), 64'(1));

    // Same dump with 4 stall cycles per word.
    run_dump(8'h00, 3, 4, sc);
    check("t2_nreads", 64'(seen_addr_q.size()), 64'(3));
    check("t2_w0", 64'(seen_word_q[0]), 64'(6));
    check("t2_w2", 64'(seen_word_q[2]), 64'(8));
    check("t2_done_after_last_xfer", 64'(done_cyc - last_xfer_cyc), 64'(1));

    // Address wrap at the top of the memory.
    mem[255] = 32'hA; mem[0] = 32'hB;
    run_dump(8'hFF, 2, 0, sc);
    check("t3_addr0", 64'(seen_addr_q[0]), 64'(8'hFF));
    check("t3_addr1", 64'(seen_addr_q[1]), 64'(8'h00));
    check("t3_w0", 64'(seen_word_q[0]), 64'(32'hA));
    check("t3_w1", 64'(seen_word_q[1]), 64'(32'hB));
    mem[0] = 32'd6;

    // Empty dump: no reads, done pulse (plus zero checksum word if enabled).
    run_dump(8'h10, 0, 0, sc);
    check("t4_nreads", 64'(seen_addr_q.size()), 64'(0));
    check("t4_nwords", 64'(seen_word_q.size()), 64'(CS ? 1 : 0));
    if (!CS) check("t4_done_latency", 64'(done_cyc - sc), 64'(1));
    if (CS) check("t4_csum_word", 64'(seen_word_q[0]), 64'(0));

    // Reset while word 2 of 3 is waiting in SEND.
    model_load(8'h00, 3);
    @(posedge clk); #1;
    start = 1'b1; base_addr = 8'h00; word_count = 9'd3; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (seen_word_q.size() < 1 && k < 50) begin @(posedge clk); #1; k++; end
    out_ready = 1'b0;
    while (!out_valid && k < 100) begin @(posedge clk); #1; k++; end
    check("t5_reached_word2", 64'(out_data), 64'(7));
    reset = 1'b1;
    exp_addr_q.delete(); exp_word_q.delete();
    expect_done = 1'b0;
    @(posedge clk); #1;
    check("t5_valid_after_reset", 64'(out_valid), 64'(0));
    check("t5_busy_after_reset", 64'(busy), 64'(0));
    check("t5_done_after_reset", 64'(done), 64'(0));
    check("t5_data_after_reset", 64'(out_data), 64'(0));
    check("t5_addr_after_reset", 64'(mem_addr), 64'(0));
    check("t5_last_after_reset", 64'(out_last), 64'(0));
    reset = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    run_dump(8'h00, 3, 0, sc);
    check("t5_redump_w0", 64'(seen_word_q[0]), 64'(6));
    check("t5_redump_w2", 64'(seen_word_q[2]), 64'(8));
    check("t5_redump_latency", 64'(first_valid_cyc - sc), 64'(3));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
